// File: rtl/fifo_rptr_empty_if.sv
// Read-side port bundle of the async FIFO: pop request, synchronised-in write pointer, read status.
// ralmost_empty exists only when FIFO_ALMOST_EMPTY_EN is defined.
interface fifo_rptr_empty_if #(
    parameter int unsigned ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [ADDRSIZE:0]   rlevel;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic                ralmost_empty;
`endif

`ifdef FIFO_ALMOST_EMPTY_EN
    modport master (output rinc, wptr, input raddr, rptr, rempty, rlevel, ralmost_empty);
    modport slave  (input rinc, wptr, output raddr, rptr, rempty, rlevel, ralmost_empty);
`else
    modport master (output rinc, wptr, input raddr, rptr, rempty, rlevel);
    modport slave  (input rinc, wptr, output raddr, rptr, rempty, rlevel);
`endif
endinterface

// File: rtl/fifo_rptr_empty.sv
// Async FIFO read-side controller: binary/Gray read pointer, wptr synchroniser, registered empty and level.
// Optional almost-empty flag enabled by defining FIFO_ALMOST_EMPTY_EN (AE_THRESH used only then).
module fifo_rptr_empty #(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic               rclk,
    input  logic               rrst_n,
    fifo_rptr_empty_if.slave   bus
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wq1;
    logic [PW-1:0] r_wq2;
    logic [PW-1:0] r_rlevel;
    logic          r_rempty;

    logic          w_pop;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_rlevel_next;

    always_comb begin
        w_pop        = bus.rinc & ~r_rempty;
        w_rbin_next  = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
        w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
        w_wbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            w_wbin[i] = ^(r_wq2 >> i);
        end
        w_rlevel_next = w_wbin - w_rbin_next;
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    logic r_ralmost_empty;
    logic w_ae_next;

    always_comb begin
        w_ae_next = (w_rlevel_next <= PW'(AE_THRESH));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_ralmost_empty <= 1'b1;
        end else begin
            r_ralmost_empty <= w_ae_next;
        end
    end

    assign bus.ralmost_empty = r_ralmost_empty;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_wq1    <= '0;
            r_wq2    <= '0;
            r_rempty <= 1'b1;
            r_rlevel <= '0;
        end else begin
            r_wq1    <= bus.wptr;
            r_wq2    <= r_wq1;
            r_rbin   <= w_rbin_next;
            r_rptr   <= w_rgray_next;
            // Compared against next pointer so popping the last word flags empty on the same edge
            r_rempty <= (w_rgray_next == r_wq2);
            r_rlevel <= w_rlevel_next;
        end
    end

    assign bus.raddr  = r_rbin[ADDRSIZE-1:0];
    assign bus.rptr   = r_rptr;
    assign bus.rempty = r_rempty;
    assign bus.rlevel = r_rlevel;
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed self-checking bench for fifo_rptr_empty (ADDRSIZE=4): sync latency, pops, wrap, streaming, async reset.
module tb_fifo_rptr_empty;
    logic rclk;
    logic rrst_n;
    int   n_cmp;
    int   n_bad;

    fifo_rptr_empty_if #(.ADDRSIZE(4)) bus ();

    fifo_rptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int unsigned b);
        logic [4:0] v;
        v = b[4:0];
        return (v >> 1) ^ v;
    endfunction

    // Advance n active edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rempty"}, int'(bus.rempty), 1);
        chk({tag, ".raddr"},  int'(bus.raddr),  0);
        chk({tag, ".rptr"},   int'(bus.rptr),   0);
        chk({tag, ".rlevel"}, int'(bus.rlevel), 0);
    endtask

    logic [4:0] prev_ptr;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rrst_n   = 1'b0;
        bus.rinc = 1'b1;
        bus.wptr = '0;

        // 1: reset, then rinc held with nothing written
        #12;
        chk_idle("rst");
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk_idle("empty_rinc");
        end

        // 2: one word arrives, visible at the third edge
        bus.rinc = 1'b0;
        bus.wptr = gray(1);
        step(1);
        chk("lat.e1.rempty", int'(bus.rempty), 1);
        step(1);
        chk("lat.e2.rempty", int'(bus.rempty), 1);
        step(1);
        chk("lat.e3.rempty", int'(bus.rempty), 0);
        chk("lat.e3.rlevel", int'(bus.rlevel), 1);
        bus.rinc = 1'b1;
        step(1);
        bus.rinc = 1'b0;
        chk("pop1.raddr",  int'(bus.raddr),  1);
        chk("pop1.rptr",   int'(bus.rptr),   1);
        chk("pop1.rempty", int'(bus.rempty), 1);
        chk("pop1.rlevel", int'(bus.rlevel), 0);

        // 3: fresh start with a full FIFO, drain 16 back-to-back
        #3 rrst_n = 1'b0;
        bus.wptr = '0;
        #1 chk_idle("rst2");
        #2 rrst_n = 1'b1;
        bus.wptr = 5'b11000;
        step(3);
        chk("full.rlevel", int'(bus.rlevel), 16);
        chk("full.rempty", int'(bus.rempty), 0);
        bus.rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk("drain.raddr", int'(bus.raddr), k - 1);
            prev_ptr = bus.rptr;
            step(1);
            chk("drain.gray1", $countones(prev_ptr ^ bus.rptr), 1);
            chk("drain.rlevel", int'(bus.rlevel), 16 - k);
            chk("drain.rempty", int'(bus.rempty), (k == 16) ? 1 : 0);
        end
        chk("drain.raddr_end", int'(bus.raddr), 0);
        chk("drain.rptr_end",  int'(bus.rptr),  5'b11000);
        step(2);
        chk("drain.hold_rptr", int'(bus.rptr), 5'b11000);

        // 4: 16 more words bring the write pointer to 32 (Gray 0); no false non-empty while syncing
        bus.rinc = 1'b0;
        bus.wptr = gray(32);
        step(1);
        chk("wrap.e1.rempty", int'(bus.rempty), 1);
        step(1);
        chk("wrap.e2.rempty", int'(bus.rempty), 1);
        step(1);
        chk("wrap.rlevel", int'(bus.rlevel), 16);
        chk("wrap.rempty", int'(bus.rempty), 0);
        bus.rinc = 1'b1;
        step(16);
        chk("wrap.end.rptr",   int'(bus.rptr),   0);
        chk("wrap.end.raddr",  int'(bus.raddr),  0);
        chk("wrap.end.rempty", int'(bus.rempty), 1);
        chk("wrap.end.rlevel", int'(bus.rlevel), 0);

        // 5: stream, one write and one pop per cycle; level settles to 2 behind the 2-flop sync
        bus.rinc = 1'b0;
        bus.wptr = gray(4);
        step(3);
        chk("strm.start", int'(bus.rlevel), 4);
        bus.rinc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.wptr = gray(4 + k);
            prev_ptr = bus.rptr;
            step(1);
            chk("strm.gray1",  $countones(prev_ptr ^ bus.rptr), 1);
            chk("strm.rlevel", int'(bus.rlevel), (k == 1) ? 3 : 2);
            chk("strm.rempty", int'(bus.rempty), 0);
        end
        chk("strm.raddr", int'(bus.raddr), 10);

        // 6: level 7 then async reset mid-cycle
        bus.rinc = 1'b0;
        bus.wptr = gray(17);
        step(3);
        chk("l7.rlevel", int'(bus.rlevel), 7);
        #3 rrst_n = 1'b0;
        bus.wptr = '0;
        #1 chk_idle("async_rst");
`ifdef FIFO_ALMOST_EMPTY_EN
        chk("async_rst.ae", int'(bus.ralmost_empty), 1);
`endif
        #2 rrst_n = 1'b1;
        step(3);
        chk_idle("post_rst");

`ifdef FIFO_ALMOST_EMPTY_EN
        bus.wptr = gray(3);
        step(3);
        chk("ae.l3.rlevel", int'(bus.rlevel), 3);
        chk("ae.l3", int'(bus.ralmost_empty), 0);
        bus.rinc = 1'b1;
        step(1);
        bus.rinc = 1'b0;
        chk("ae.l2.rlevel", int'(bus.rlevel), 2);
        chk("ae.l2", int'(bus.ralmost_empty), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
